power_mode_sequencer: RTL and testbench

Drives the `power_mode` input of the power controller and consumes its `power_state`, `idle_counter` and `system_wakeup` outputs, closing the power-management loop. It arbitrates between three mode sources: host mode requests, automatic idle-based step-down and wakeup return-to-normal. It generates the periodic `timer_wakeup` used in sleep mode and verifies that the controller's reported state follows each commanded mode. It sits beside the power controller in the IoT sensor controller top level.

---
 rtl/iot_sensor_pkg.sv | 36 +++
 rtl/pwr_wake_timer.sv | 33 +++
 rtl/power_mode_sequencer.sv | 163 ++++++++++++++++
 tb/tb_power_mode_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_sensor_pkg.sv
// Shared power-management types for the IoT sensor controller: power modes,
// sequencer states, mode-to-state map and default idle thresholds.
package iot_sensor_pkg;

    typedef enum logic [1:0] {
        PM_NORMAL = 2'b00,
        PM_LOW    = 2'b01,
        PM_SLEEP  = 2'b10,
        PM_DEEP   = 2'b11
    } power_mode_e;

    typedef enum logic {
        SEQ_RUN    = 1'b0,
        SEQ_SETTLE = 1'b1
    } seq_state_e;

    localparam logic [15:0] DEF_LOW_IDLE_THRESH   = 16'd1000;
    localparam logic [15:0] DEF_SLEEP_IDLE_THRESH = 16'd8000;
    localparam logic [15:0] DEF_DEEP_IDLE_THRESH  = 16'hF000;
    localparam logic [23:0] DEF_WAKE_PERIOD       = 24'd50000;
    localparam logic [3:0]  DEF_SETTLE_CYCLES     = 4'd8;

    // One-hot state the power controller reports for each mode; DEEP is all-off.
    function automatic logic [2:0] mode_to_state(input power_mode_e mode);
        logic [2:0] state;
        state = 3'b000;
        case (mode)
            PM_NORMAL: state = 3'b001;
            PM_LOW:    state = 3'b010;
            PM_SLEEP:  state = 3'b100;
            default:   state = 3'b000;
        endcase
        return state;
    endfunction

endpackage

// File: rtl/pwr_wake_timer.sv
// Free-running period counter for sleep-mode wakeups: while enabled it emits a
// registered one-cycle pulse every WAKE_PERIOD cycles; disabled it holds at 0.
module pwr_wake_timer #(
    parameter logic [23:0] WAKE_PERIOD = 24'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_pulse
);

    logic [23:0] r_cnt;
    logic        r_pulse;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= 24'd0;
            r_pulse <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= 24'd0;
            r_pulse <= 1'b0;
        end else if (r_cnt == WAKE_PERIOD - 24'd1) begin
            r_cnt   <= 24'd0;
            r_pulse <= 1'b1;
        end else begin
            r_cnt   <= r_cnt + 24'd1;
            r_pulse <= 1'b0;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/power_mode_sequencer.sv
// Arbitrates host requests, idle step-down and wakeups into the power_mode
// command, then checks the controller follows. Macro PWR_SEQ_TIMER_WAKE_EN adds the sleep wake timer.
module power_mode_sequencer
    import iot_sensor_pkg::*;
#(
    parameter logic [15:0] LOW_IDLE_THRESH   = DEF_LOW_IDLE_THRESH,
    parameter logic [15:0] SLEEP_IDLE_THRESH = DEF_SLEEP_IDLE_THRESH,
    parameter logic [15:0] DEEP_IDLE_THRESH  = DEF_DEEP_IDLE_THRESH,
    parameter logic [23:0] WAKE_PERIOD       = DEF_WAKE_PERIOD,
    parameter logic [3:0]  SETTLE_CYCLES     = DEF_SETTLE_CYCLES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        global_enable,
    input  logic [15:0] idle_counter,
    input  logic [2:0]  power_state,
    input  logic        system_wakeup,
    input  logic        auto_en,
    input  logic        host_req_valid,
    input  logic [1:0]  host_req_mode,
    output logic        host_req_ready,
    output logic [1:0]  power_mode,
    output logic        timer_wakeup,
    output logic        mode_changed,
    output logic [7:0]  wake_count,
    output logic        state_mismatch,
    output logic        seq_busy
);

    // Host handshake: a request is taken in any cycle where host_req_valid and
    // host_req_ready are both high; the host holds valid and mode until then.
    seq_state_e  r_state;
    power_mode_e r_cur_mode;
    logic [3:0]  r_settle_cnt;
    logic        r_wake_pending;
    logic        r_rearm;
    logic        r_mode_changed;
    logic        r_mismatch;
    logic [7:0]  r_wake_count;

    logic        w_run;
    logic        w_ready;
    logic        w_low_power;
    logic        w_wake_svc;
    logic        w_host_fire;
    logic        w_auto_step;
    logic [15:0] w_step_thresh;

    assign w_run       = (r_state == SEQ_RUN);
    assign w_ready     = rst_n & w_run & global_enable & ~r_wake_pending & ~system_wakeup;
    assign w_low_power = (r_cur_mode == PM_SLEEP) || (r_cur_mode == PM_DEEP);
    assign w_wake_svc  = (system_wakeup | r_wake_pending) & w_low_power;
    assign w_host_fire = host_req_valid & w_ready;

    always_comb begin
        w_step_thresh = DEEP_IDLE_THRESH;
        case (r_cur_mode)
            PM_NORMAL: w_step_thresh = LOW_IDLE_THRESH;
            PM_LOW:    w_step_thresh = SLEEP_IDLE_THRESH;
            default:   w_step_thresh = DEEP_IDLE_THRESH;
        endcase
    end

    assign w_auto_step = auto_en & r_rearm & (r_cur_mode != PM_DEEP) &
                         (idle_counter >= w_step_thresh);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= SEQ_RUN;
            r_cur_mode     <= PM_NORMAL;
            r_settle_cnt   <= 4'd0;
            r_wake_pending <= 1'b0;
            r_rearm        <= 1'b1;
            r_mode_changed <= 1'b0;
            r_mismatch     <= 1'b0;
            r_wake_count   <= 8'd0;
        end else begin
            r_mode_changed <= 1'b0;
            if (!global_enable) begin
                r_state        <= SEQ_RUN;
                r_cur_mode     <= PM_NORMAL;
                r_mode_changed <= (r_cur_mode != PM_NORMAL);
                r_settle_cnt   <= 4'd0;
                r_wake_pending <= 1'b0;
            end else begin
                case (r_state)
                    SEQ_RUN: begin
                        // Any pending wake is either serviced now or stale.
                        r_wake_pending <= 1'b0;
                        if (w_wake_svc) begin
                            r_cur_mode     <= PM_NORMAL;
                            r_mode_changed <= 1'b1;
                            r_rearm        <= 1'b0;
                            r_state        <= SEQ_SETTLE;
                            r_settle_cnt   <= SETTLE_CYCLES - 4'd1;
                            if (r_wake_count != 8'hFF) begin
                                r_wake_count <= r_wake_count + 8'd1;
                            end
                        end else if (w_host_fire) begin
                            if (host_req_mode != r_cur_mode) begin
                                r_cur_mode     <= power_mode_e'(host_req_mode);
                                r_mode_changed <= 1'b1;
                                r_state        <= SEQ_SETTLE;
                                r_settle_cnt   <= SETTLE_CYCLES - 4'd1;
                            end
                        end else if (w_auto_step) begin
                            r_cur_mode     <= power_mode_e'(r_cur_mode + 2'd1);
                            r_mode_changed <= 1'b1;
                            r_state        <= SEQ_SETTLE;
                            r_settle_cnt   <= SETTLE_CYCLES - 4'd1;
                        end
                    end
                    SEQ_SETTLE: begin
                        if (system_wakeup) begin
                            r_wake_pending <= 1'b1;
                        end
                        if (r_settle_cnt == 4'd0) begin
                            r_state <= SEQ_RUN;
                            if (power_state != mode_to_state(r_cur_mode)) begin
                                r_mismatch <= 1'b1;
                            end
                        end else begin
                            r_settle_cnt <= r_settle_cnt - 4'd1;
                        end
                    end
                    default: r_state <= SEQ_RUN;
                endcase
            end
            // A low idle level re-arms step-down and overrides the clear on wake.
            if (idle_counter < LOW_IDLE_THRESH) begin
                r_rearm <= 1'b1;
            end
        end
    end

`ifdef PWR_SEQ_TIMER_WAKE_EN
    logic w_timer_en;
    logic w_timer_pulse;

    assign w_timer_en = global_enable & w_run & (r_cur_mode == PM_SLEEP);

    pwr_wake_timer #(
        .WAKE_PERIOD (WAKE_PERIOD)
    ) u_wake_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_timer_en),
        .o_pulse (w_timer_pulse)
    );

    assign timer_wakeup = w_timer_pulse;
`else
    assign timer_wakeup = 1'b0;
`endif

    assign host_req_ready = w_ready;
    assign power_mode     = r_cur_mode;
    assign mode_changed   = r_mode_changed;
    assign wake_count     = r_wake_count;
    assign state_mismatch = r_mismatch;
    assign seq_busy       = (r_state == SEQ_SETTLE);

endmodule

// File: tb/tb_power_mode_sequencer.sv
// Bench for power_mode_sequencer: stub power controller, cycle reference model,
// a vector table, directed corner sequences and a randomized phase.
module tb_power_mode_sequencer;

    localparam logic [23:0] WP = 24'd100;
    localparam int          S  = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        global_enable;
    logic [15:0] idle_counter;
    logic [2:0]  power_state;
    logic        system_wakeup;
    logic        auto_en;
    logic        host_req_valid;
    logic [1:0]  host_req_mode;
    logic        host_req_ready;
    logic [1:0]  power_mode;
    logic        timer_wakeup;
    logic        mode_changed;
    logic [7:0]  wake_count;
    logic        state_mismatch;
    logic        seq_busy;

    logic motion;
    logic loop_en;
    logic stub;
    logic ctl_wake;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int m_mode, m_busy, m_pend, m_rearm, m_wc, m_mis, m_chg, m_timer, m_tw;

    typedef struct {
        logic       hv;
        logic [1:0] hm;
        logic       exp_rdy;
        logic [1:0] exp_mode;
        logic       exp_chg;
        logic       exp_busy;
    } vec_t;
    vec_t tbl[11];

    logic [1:0] exp_q[$];
    int         pulse_t[$];

    power_mode_sequencer #(
        .WAKE_PERIOD   (WP),
        .SETTLE_CYCLES (4'd8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .global_enable  (global_enable),
        .idle_counter   (idle_counter),
        .power_state    (power_state),
        .system_wakeup  (system_wakeup),
        .auto_en        (auto_en),
        .host_req_valid (host_req_valid),
        .host_req_mode  (host_req_mode),
        .host_req_ready (host_req_ready),
        .power_mode     (power_mode),
        .timer_wakeup   (timer_wakeup),
        .mode_changed   (mode_changed),
        .wake_count     (wake_count),
        .state_mismatch (state_mismatch),
        .seq_busy       (seq_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] pmap(input int m);
        case (m)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int thr_of(input int m);
        case (m)
            0:       return 1000;
            1:       return 8000;
            default: return 32'hF000;
        endcase
    endfunction

    // Stub controller: registers the commanded state and loops timer wakeups back.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            power_state <= 3'b001;
            ctl_wake    <= 1'b0;
        end else begin
            power_state <= stub ? 3'b001 : pmap(int'(power_mode));
            ctl_wake    <= timer_wakeup;
        end
    end

    assign system_wakeup = (ctl_wake & loop_en) | motion;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_busy = 0; m_pend = 0; m_rearm = 1; m_wc = 0;
        m_mis = 0; m_chg = 0; m_timer = 0; m_tw = 0;
    endtask

    function automatic int model_ready();
        return (m_busy == 0 && global_enable && !m_pend && !system_wakeup) ? 1 : 0;
    endfunction

    task automatic model_step();
        int rdy, run, ten, svc;
        rdy = model_ready();
        run = (m_busy == 0);
        ten = (global_enable && run && m_mode == 2);
        svc = 0;
        m_chg = 0;
`ifdef PWR_SEQ_TIMER_WAKE_EN
        if (ten != 0) begin
            if (m_timer == int'(WP) - 1) begin m_timer = 0; m_tw = 1; end
            else begin m_timer++; m_tw = 0; end
        end else begin
            m_timer = 0; m_tw = 0;
        end
`else
        m_tw = 0;
`endif
        if (!global_enable) begin
            m_chg = (m_mode != 0);
            m_mode = 0; m_busy = 0; m_pend = 0;
        end else if (run == 0) begin
            if (system_wakeup) m_pend = 1;
            m_busy--;
            if (m_busy == 0 && power_state != pmap(m_mode)) m_mis = 1;
        end else begin
            if ((system_wakeup || m_pend != 0) && m_mode >= 2) begin
                m_mode = 0; m_chg = 1; m_busy = S; svc = 1;
                if (m_wc < 255) m_wc++;
            end else if (host_req_valid && rdy != 0) begin
                if (int'(host_req_mode) != m_mode) begin
                    m_mode = int'(host_req_mode); m_chg = 1; m_busy = S;
                end
            end else if (auto_en && m_rearm != 0 && m_mode < 3 &&
                         int'(idle_counter) >= thr_of(m_mode)) begin
                m_mode++; m_chg = 1; m_busy = S;
            end
            m_pend = 0;
        end
        if (idle_counter < 16'd1000) m_rearm = 1;
        else if (svc != 0) m_rearm = 0;
    endtask

    // One clock: check the combinational ready, step the model, check registered outputs.
    task automatic tick();
        #1;
        chk("host_req_ready", host_req_ready, model_ready());
        model_step();
        @(negedge clk);
        chk("power_mode", power_mode, m_mode);
        chk("mode_changed", mode_changed, m_chg);
        chk("seq_busy", seq_busy, (m_busy > 0) ? 1 : 0);
        chk("wake_count", wake_count, m_wc);
        chk("state_mismatch", state_mismatch, m_mis);
        chk("timer_wakeup", timer_wakeup, m_tw);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        global_enable = 1'b1; idle_counter = 16'd0; auto_en = 1'b0;
        host_req_valid = 1'b0; host_req_mode = 2'd0;
        motion = 1'b0; loop_en = 1'b1; stub = 1'b0;
        #1;
        chk("rst_power_mode", power_mode, 0);
        chk("rst_timer_wakeup", timer_wakeup, 0);
        chk("rst_mode_changed", mode_changed, 0);
        chk("rst_wake_count", wake_count, 0);
        chk("rst_state_mismatch", state_mismatch, 0);
        chk("rst_seq_busy", seq_busy, 0);
        chk("rst_host_req_ready", host_req_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_mode(input int m, input int lim);
        int k;
        k = 0;
        while (int'(power_mode) != m && k < lim) begin
            tick();
            k++;
        end
        chk("wait_mode", power_mode, m);
    endtask

    task automatic host_req(input logic [1:0] mode);
        host_req_valid = 1'b1;
        host_req_mode  = mode;
        tick();
        host_req_valid = 1'b0;
    endtask

    initial begin
        int seen_chg;
        int idle_v;
        logic [1:0] exp_m;

        tbl[0] = '{1'b1, 2'd3, 1'b1, 2'd3, 1'b1, 1'b1};
        for (int k = 1; k <= 7; k++) tbl[k] = '{1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 2'd0, 1'b1, 2'd0, 1'b1, 1'b1};
        tbl[10] = '{1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1};

        do_reset();

        // Host DEEP request and its settle window, then a request back to NORMAL.
        for (int k = 0; k < 11; k++) begin
            host_req_valid = tbl[k].hv;
            host_req_mode  = tbl[k].hm;
            #1;
            chk("tbl_ready", host_req_ready, tbl[k].exp_rdy);
            tick();
            chk("tbl_mode", power_mode, tbl[k].exp_mode);
            chk("tbl_changed", mode_changed, tbl[k].exp_chg);
            chk("tbl_busy", seq_busy, tbl[k].exp_busy);
        end
        host_req_valid = 1'b0;
        repeat (8) tick();
        host_req(2'd0);
        chk("same_mode_changed", mode_changed, 0);
        chk("same_mode_busy", seq_busy, 0);

        // Reset arriving mid-settle clears everything at once.
        host_req(2'd3);
        repeat (3) tick();
        chk("pre_async_busy", seq_busy, 1);
        do_reset();

        // Idle ramp with auto step-down: one step per threshold.
        loop_en = 1'b0;
        auto_en = 1'b1;
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        seen_chg = 0;
        for (idle_v = 0; idle_v < 32'hF000 + 64 * 20; idle_v += 64) begin
            idle_counter = (idle_v > 32'hF000) ? 16'hF000 : idle_v[15:0];
            tick();
            if (mode_changed) begin
                seen_chg++;
                if (exp_q.size() > 0) begin
                    exp_m = exp_q.pop_front();
                    chk("ramp_step", power_mode, exp_m);
                end else begin
                    chk("ramp_extra_step", seen_chg, 3);
                end
            end
        end
        chk("ramp_steps", seen_chg, 3);
        chk("ramp_final", power_mode, 3);

        // Sleep: wake timer period, loop-back wakeup, no re-sleep until idle drops.
        do_reset();
        loop_en = 1'b0;
        host_req(2'd2);
        repeat (8) tick();
        for (int k = 0; k < 320; k++) begin
            tick();
            if (timer_wakeup) pulse_t.push_back(k);
        end
`ifdef PWR_SEQ_TIMER_WAKE_EN
        chk("timer_pulses", pulse_t.size(), 3);
        if (pulse_t.size() >= 3) begin
            chk("timer_period_a", pulse_t[1] - pulse_t[0], 100);
            chk("timer_period_b", pulse_t[2] - pulse_t[1], 100);
        end
        idle_counter = 16'hFFFF;
        loop_en = 1'b1;
        wait_mode(0, 150);
`else
        chk("timer_pulses", pulse_t.size(), 0);
        idle_counter = 16'hFFFF;
        motion = 1'b1;
        tick();
        motion = 1'b0;
        wait_mode(0, 5);
`endif
        chk("wake_count_one", wake_count, 1);
        auto_en = 1'b1;
        repeat (50) tick();
        chk("no_resleep", power_mode, 0);
        idle_counter = 16'd500;
        tick();
        idle_counter = 16'hFFFF;
        repeat (3) tick();
        chk("rearmed_step", power_mode, 1);

        // Drop global_enable while in DEEP.
        auto_en = 1'b0;
        repeat (10) tick();
        host_req(2'd3);
        repeat (8) tick();
        chk("deep_before_ge", power_mode, 3);
        global_enable = 1'b0;
        tick();
        chk("ge_mode", power_mode, 0);
        chk("ge_changed", mode_changed, 1);
        chk("ge_wake_count", wake_count, 1);
        chk("ge_busy", seq_busy, 0);
        global_enable = 1'b1;
        tick();

        // Wakeup during the settle window into SLEEP is held then serviced.
        do_reset();
        host_req(2'd2);
        tick();
        motion = 1'b1;
        tick();
        motion = 1'b0;
        repeat (6) tick();
        chk("pend_still_sleep", power_mode, 2);
        chk("pend_settle_done", seq_busy, 0);
        tick();
        chk("pend_normal", power_mode, 0);
        chk("pend_wake_count", wake_count, 1);

        // Controller that never leaves NORMAL.
        do_reset();
        stub = 1'b1;
        host_req(2'd1);
        repeat (7) tick();
        chk("mismatch_early", state_mismatch, 0);
        tick();
        chk("mismatch_set", state_mismatch, 1);
        stub = 1'b0;
        repeat (2) tick();
        host_req(2'd0);
        repeat (12) tick();
        chk("mismatch_sticky", state_mismatch, 1);

        // Randomized phase against the reference model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 5))
                0:       idle_counter = 16'd0;
                1:       idle_counter = 16'd500;
                2:       idle_counter = 16'd1500;
                3:       idle_counter = 16'd9000;
                4:       idle_counter = 16'hF100;
                default: idle_counter = 16'($urandom_range(0, 65535));
            endcase
            global_enable  = ($urandom_range(0, 31) != 0);
            auto_en        = ($urandom_range(0, 1) != 0);
            host_req_valid = ($urandom_range(0, 3) == 0);
            host_req_mode  = 2'($urandom_range(0, 3));
            motion         = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) stub = ~stub;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
